stop_switch_conditioner: RTL
============================

Name: stop_switch_conditioner

Overview:
Conditions the two raw Y-axis limit (kill) switches and produces the debounced `stop_y[1:0]` bus consumed by `servo_control`.
- `stop_y[1]` = upper switch, `stop_y[0]` = lower switch; 1 = clear, 0 = tripped.
- Per channel: 2-flop synchronisation, debounce, sticky trip flags, saturating trip counters and a maskable interrupt.
- The block is an APB3 slave on the same bus as the servo controller.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a new level (10 ms at 100 MHz); legal range 2..2^24-1.
- FAST_TRIP, 1, when 1 a clear->tripped transition bypasses the debounce; release (tripped->clear) is always debounced.
- CNT_W, 16, width of each saturating trip counter.

Ports:
- PCLK  in  1  system clock
- PRESET  in  1  asynchronous, active-high reset
- PSEL  in  1  APB peripheral select
- PENABLE  in  1  APB access phase
- PWRITE  in  1  APB write/read
- PADDR  in  32  APB address; PADDR[7:0] decoded
- PWDATA  in  32  APB write data
- PRDATA  out  32  APB read data, registered
- PREADY  out  1  tied 1
- PSLVERR  out  1  tied 0
- raw_stop  in  2  asynchronous switch inputs, 1 = clear
- stop_y  out  2  debounced switch state to servo_control
- trip_irq  out  1  interrupt, level

Behaviour:
- Reset (async, PRESET=1):
  - Sync flops, stop_y, trip_latched, irq_en, counters, debounce counters: all 0. PRDATA = 0.
  - stop_y = 00 means both directions are blocked until each switch is proven clear (safe default).
- Synchroniser: raw_stop passes through 2 flops to give sync[1:0]. This is the only logic that samples raw_stop.
- Debounce, per channel i:
  - If sync[i] == stop_y[i], the counter clears to 0.
  - Otherwise the counter increments. On the cycle it equals DEBOUNCE_CYCLES-1, stop_y[i] <= sync[i] and the counter clears.
  - Release latency from a raw edge: 2 + DEBOUNCE_CYCLES cycles. A glitch shorter than DEBOUNCE_CYCLES produces no output change.
  - FAST_TRIP=1: if sync[i]==0 while stop_y[i]==1, stop_y[i] <= 0 on the next edge (latency 3 cycles from the raw edge) and the counter clears.
- Trip event trip_ev[i]: registered stop_y[i] transition 1->0.
  - Sets trip_latched[i].
  - Increments trip_cnt[i], saturating at 2^CNT_W-1.
- trip_latched is W1C via TRIP_CLR. If set and clear occur in the same cycle, set wins.
- COUNT_CLR with a trip_ev in the same cycle: that channel's counter ends at 1; the other channel ends at 0.
- trip_irq = |(trip_latched & irq_en), combinational from registers.
- Writes are qualified by PSEL && PWRITE && PENABLE. Register map (PADDR[7:0]):
  - 0x00 STATUS, RO: [1:0] stop_y, [3:2] sync, [5:4] trip_latched, rest 0.
  - 0x04 TRIP_CLR, W1C: PWDATA[1:0]; reads 0.
  - 0x08 IRQ_EN, RW: [1:0]; reset 0.
  - 0x0C TRIP_COUNT, RO: [15:0] ch0, [31:16] ch1 (zero-extended if CNT_W<16).
  - 0x10 COUNT_CLR, write any: zeroes both counters; reads 0.
- Reads:
  - PRDATA is updated every posedge from decode of PSEL && !PWRITE && address. It is valid in the access phase.
  - Unmapped reads, and cycles with no read select, return 0xFFFFFFFF.
- Reset mid-debounce: counters drop to 0 immediately and stop_y returns to 00. On release of reset, a full debounce is required before any channel reads clear.

Decomposition:
- Package stop_switch_pkg:
  - register offsets (STATUS, TRIP_CLR, IRQ_EN, TRIP_COUNT, COUNT_CLR)
  - STATUS bit positions
  - DEBOUNCE_CYCLES default
  - unmapped-read constant 0xFFFFFFFF
- Sub-module _switch_debounce: one channel, covering the synchroniser, debounce counter, FAST_TRIP path and trip_ev output. Instantiated twice.
- APB decode, W1C flags, counters and IRQ stay in the top level.

Test Plan (DEBOUNCE_CYCLES=8, FAST_TRIP=1 unless stated):
1. Reset, then raw_stop=11 held -> stop_y=00 until cycle 10 after reset release, then 11; STATUS read = 0x0F.
2. stop_y=11, raw_stop[0] pulsed low 1 cycle -> stop_y[0]=0 at cycle 3, trip_latched[0]=1, TRIP_COUNT=0x00000001. Re-release is debounced: stop_y[0]=1 only after 8 stable cycles.
3. FAST_TRIP=0, raw_stop[1] low for 5 cycles then high -> stop_y stays 11, no trip, TRIP_COUNT=0. Low for 8 cycles -> stop_y[1]=0 at cycle 10.
4. IRQ_EN=01, trip ch0 -> trip_irq=1. Write TRIP_CLR=0x1 -> trip_irq=0 next cycle. Write TRIP_CLR in the same cycle as a new trip_ev -> flag stays 1.
5. Force 65536 trips on ch1 -> TRIP_COUNT[31:16]=0xFFFF (saturated). Write COUNT_CLR coincident with a ch0 trip -> TRIP_COUNT=0x00000001.
6. Read PADDR=0x20 -> PRDATA=0xFFFFFFFF. Assert PRESET mid-debounce (counter=5) -> stop_y=00 immediately, debounce restarts from 0.

Source files
------------

// File: rtl/stop_switch_pkg.sv
// Shared constants for the Y-axis limit-switch conditioner: APB register
// offsets, STATUS field positions and default debounce length.
package stop_switch_pkg;

    // APB register offsets, decoded on PADDR[7:0]
    localparam logic [7:0] ADDR_STATUS     = 8'h00;
    localparam logic [7:0] ADDR_TRIP_CLR   = 8'h04;
    localparam logic [7:0] ADDR_IRQ_EN     = 8'h08;
    localparam logic [7:0] ADDR_TRIP_COUNT = 8'h0C;
    localparam logic [7:0] ADDR_COUNT_CLR  = 8'h10;

    // STATUS field LSB positions, each field is two bits wide
    localparam int STAT_STOP_LSB = 0;
    localparam int STAT_SYNC_LSB = 2;
    localparam int STAT_TRIP_LSB = 4;

    // 10 ms at 100 MHz
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;

    // Debounce counter width, large enough for DEBOUNCE_CYCLES up to 2^24-1
    localparam int DEB_CNT_W = 24;

    // Read data for unmapped addresses and idle cycles
    localparam logic [31:0] RD_UNMAPPED = 32'hFFFF_FFFF;

endpackage

// File: rtl/stop_switch_conditioner_switch_debounce.sv
// One limit-switch channel: 2-flop synchroniser, debounce counter with an
// optional fast path for clear->tripped, and a registered trip event pulse.
module stop_switch_conditioner_switch_debounce
    import stop_switch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter bit          FAST_TRIP       = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic sync_o,
    output logic stop_o,
    output logic trip_ev_o
);

    localparam logic [DEB_CNT_W-1:0] CNT_LAST = DEB_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                 meta_q;
    logic                 sync_q;
    logic                 stop_q;
    logic                 stop_d;
    logic                 trip_ev_q;
    logic [DEB_CNT_W-1:0] cnt_q;
    logic [DEB_CNT_W-1:0] cnt_d;

    // Synchronise the asynchronous switch input; nothing else samples raw_i
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= raw_i;
            sync_q <= meta_q;
        end
    end

    // Debounce: count consecutive cycles of disagreement, accept on the last
    always_comb begin
        stop_d = stop_q;
        cnt_d  = '0;
        if (sync_q != stop_q) begin
            if (FAST_TRIP && !sync_q) begin
                // Tripping is never delayed when the fast path is enabled
                stop_d = 1'b0;
            end else if (cnt_q == CNT_LAST) begin
                stop_d = sync_q;
            end else begin
                cnt_d = cnt_q + DEB_CNT_W'(1);
            end
        end
    end

    // Debounced level, counter and the 1->0 trip event register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stop_q    <= 1'b0;
            cnt_q     <= '0;
            trip_ev_q <= 1'b0;
        end else begin
            stop_q    <= stop_d;
            cnt_q     <= cnt_d;
            trip_ev_q <= stop_q & ~stop_d;
        end
    end

    assign sync_o    = sync_q;
    assign stop_o    = stop_q;
    assign trip_ev_o = trip_ev_q;

endmodule

// File: rtl/stop_switch_conditioner.sv
// Y-axis limit-switch conditioner: two debounced channels feeding stop_y,
// sticky trip flags, saturating trip counters and a maskable level IRQ,
// all exposed through an APB3 slave.
module stop_switch_conditioner
    import stop_switch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter bit          FAST_TRIP       = 1'b1,
    parameter int unsigned CNT_W           = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    input  logic [1:0]  raw_stop,
    output logic [1:0]  stop_y,
    output logic        trip_irq
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]             sync;
    logic [1:0]             trip_ev;
    logic [1:0]             trip_latched_q, trip_latched_d;
    logic [1:0]             irq_en_q, irq_en_d;
    logic [1:0][CNT_W-1:0]  trip_cnt_q, trip_cnt_d;
    logic [31:0]            prdata_q, prdata_d;
    logic                   wr_en;
    logic                   rd_en;
    logic [7:0]             addr;
    logic [1:0]             trip_clr;
    logic                   count_clr;
    logic [31:0]            status;
    logic                   unused_ok;

    // Map a trip counter onto a 16-bit TRIP_COUNT half, zero-extending
    function automatic logic [15:0] cnt16(input logic [CNT_W-1:0] c);
        logic [CNT_W+15:0] ext;
        ext = {16'b0, c};
        return ext[15:0];
    endfunction

    for (genvar i = 0; i < 2; i++) begin : g_ch
        stop_switch_conditioner_switch_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .FAST_TRIP       (FAST_TRIP)
        ) u_deb (
            .clk_i     (PCLK),
            .rst_i     (PRESET),
            .raw_i     (raw_stop[i]),
            .sync_o    (sync[i]),
            .stop_o    (stop_y[i]),
            .trip_ev_o (trip_ev[i])
        );
    end

    assign wr_en     = PSEL & PWRITE & PENABLE;
    assign rd_en     = PSEL & ~PWRITE;
    assign addr      = PADDR[7:0];
    assign trip_clr  = (wr_en && addr == ADDR_TRIP_CLR) ? PWDATA[1:0] : 2'b00;
    assign count_clr = wr_en && (addr == ADDR_COUNT_CLR);

    // Next state for flags, IRQ enable and trip counters; a new trip wins over clears
    always_comb begin
        trip_latched_d = (trip_latched_q & ~trip_clr) | trip_ev;
        irq_en_d       = (wr_en && addr == ADDR_IRQ_EN) ? PWDATA[1:0] : irq_en_q;
        trip_cnt_d     = trip_cnt_q;
        for (int ch = 0; ch < 2; ch++) begin
            if (count_clr) begin
                trip_cnt_d[ch] = CNT_W'(trip_ev[ch]);
            end else if (trip_ev[ch] && trip_cnt_q[ch] != CNT_MAX) begin
                trip_cnt_d[ch] = trip_cnt_q[ch] + CNT_W'(1);
            end
        end
    end

    // Read mux; anything other than a mapped read returns all ones
    always_comb begin
        status                           = '0;
        status[STAT_STOP_LSB +: 2]       = stop_y;
        status[STAT_SYNC_LSB +: 2]       = sync;
        status[STAT_TRIP_LSB +: 2]       = trip_latched_q;
        prdata_d                         = RD_UNMAPPED;
        if (rd_en) begin
            case (addr)
                ADDR_STATUS:     prdata_d = status;
                ADDR_TRIP_CLR:   prdata_d = '0;
                ADDR_IRQ_EN:     prdata_d = {30'b0, irq_en_q};
                ADDR_TRIP_COUNT: prdata_d = {cnt16(trip_cnt_q[1]), cnt16(trip_cnt_q[0])};
                ADDR_COUNT_CLR:  prdata_d = '0;
                default:         prdata_d = RD_UNMAPPED;
            endcase
        end
    end

    // Register state and read data
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            trip_latched_q <= '0;
            irq_en_q       <= '0;
            trip_cnt_q     <= '0;
            prdata_q       <= '0;
        end else begin
            trip_latched_q <= trip_latched_d;
            irq_en_q       <= irq_en_d;
            trip_cnt_q     <= trip_cnt_d;
            prdata_q       <= prdata_d;
        end
    end

    assign PRDATA    = prdata_q;
    assign PREADY    = 1'b1;
    assign PSLVERR   = 1'b0;
    assign trip_irq  = |(trip_latched_q & irq_en_q);
    assign unused_ok = ^{PADDR[31:8], PWDATA[31:2]};

endmodule
